// File: rtl/mpq_pkg.sv
// mpq_pkg: shared opcodes, FSM states and the key ordering used by the heap.
package mpq_pkg;

   // Widest key the ordering function accepts; callers zero-extend into it.
   localparam int KEY_MAX_W = 64;

   typedef enum logic [2:0] {
      OP_BUILD   = 3'd0,
      OP_EXTRACT = 3'd1,
      OP_UPDATE  = 3'd2,
      OP_INSERT  = 3'd3,
      OP_WRITE   = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BUILD,
      S_SIFT_DN,
      S_SIFT_UP,
      S_WRITE
   } state_e;

   // True when a should sit above b: strictly greater for a max-heap,
   // strictly smaller for a min-heap.
   function automatic logic better(input logic                 min_mode,
                                   input logic [KEY_MAX_W-1:0] a,
                                   input logic [KEY_MAX_W-1:0] b);
      return min_mode ? (a < b) : (a > b);
   endfunction

endpackage

// File: rtl/mpq_cmp_swap.sv
// mpq_cmp_swap: picks the better of a node and its (up to two) children and
// reports whether the node has to be swapped with that child.
module mpq_cmp_swap
   import mpq_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int MIN_MODE = 0
) (
   input  logic [DATA_W-1:0] node,
   input  logic [DATA_W-1:0] left,
   input  logic [DATA_W-1:0] right,
   input  logic              l_ok,
   input  logic              r_ok,
   output logic              swap,
   output logic              pick_right,
   output logic [DATA_W-1:0] best
);

   localparam logic MM = (MIN_MODE != 0);

   // Right child wins only when strictly better, so ties go to the left child.
   always_comb begin
      pick_right = r_ok && better(MM, KEY_MAX_W'(right), KEY_MAX_W'(left));
      best       = pick_right ? right : left;
      swap       = l_ok && better(MM, KEY_MAX_W'(best), KEY_MAX_W'(node));
   end

endmodule

// File: rtl/mpq_heap.sv
// mpq_heap: register-array binary heap (max or min) with load, build, extract,
// insert, update and a sequential RAM dump of the array.
// Optional feature: define MPQ_HEAP_ERR_EN to pulse err on rejected commands.
module mpq_heap
   import mpq_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = 8,
   parameter int MIN_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              data_valid,
   input  logic [DATA_W-1:0] data,
   input  logic              cmd_valid,
   input  logic [2:0]        cmd,
   input  logic [ADDR_W-1:0] index,
   input  logic [DATA_W-1:0] value,
   output logic              busy,
   output logic              RAM_valid,
   output logic [ADDR_W-1:0] RAM_A,
   output logic [DATA_W-1:0] RAM_D,
   output logic              done,
   output logic [ADDR_W:0]   count,
   output logic              err
);

   localparam int              IW      = $clog2(DEPTH);
   localparam logic            MM      = (MIN_MODE != 0);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] heap [DEPTH];

   state_e            state;
   logic [ADDR_W-1:0] cur;        // node currently being sifted
   logic [ADDR_W-1:0] bnode;      // BUILD: nodes still to sift (next is bnode-1)
   logic              bld;        // sift-down belongs to a BUILD pass
   logic [ADDR_W:0]   ptr;        // WRITE read pointer

   logic [ADDR_W+1:0] lc, rc;
   logic [ADDR_W-1:0] par;
   logic [IW-1:0]     last_idx;
   logic              l_ok, r_ok, swap_dn, pick_right, swap_up;
   logic [DATA_W-1:0] node_d, left_d, right_d, par_d, best_d, last_d, old_d;
   logic              cmd_ok, load_ok, upd_better;

   logic              wa_en, wb_en;
   logic [IW-1:0]     wa_idx, wb_idx;
   logic [DATA_W-1:0] wa_dat, wb_dat;

   // Neighbour addressing and array reads for the current node.
   always_comb begin
      lc         = {1'b0, cur, 1'b1};
      rc         = lc + 1;
      l_ok       = lc < {1'b0, count};
      r_ok       = rc < {1'b0, count};
      par        = (cur - 1) >> 1;
      last_idx   = count[IW-1:0] - 1;
      node_d     = heap[cur[IW-1:0]];
      left_d     = heap[lc[IW-1:0]];
      right_d    = heap[rc[IW-1:0]];
      par_d      = heap[par[IW-1:0]];
      last_d     = heap[last_idx];
      old_d      = heap[index[IW-1:0]];
      upd_better = better(MM, KEY_MAX_W'(value), KEY_MAX_W'(old_d));
      swap_up    = (cur != '0) && better(MM, KEY_MAX_W'(node_d), KEY_MAX_W'(par_d));
   end

   mpq_cmp_swap #(
      .DATA_W   (DATA_W),
      .MIN_MODE (MIN_MODE)
   ) u_cmp_swap (
      .node       (node_d),
      .left       (left_d),
      .right      (right_d),
      .l_ok       (l_ok),
      .r_ok       (r_ok),
      .swap       (swap_dn),
      .pick_right (pick_right),
      .best       (best_d)
   );

   // Command acceptance: only while idle, and only when the command can run.
   always_comb begin
      cmd_ok = 1'b0;
      if (cmd_valid && !busy) begin
         case (cmd)
            OP_BUILD,
            OP_WRITE:   cmd_ok = 1'b1;
            OP_EXTRACT: cmd_ok = (count != '0);
            OP_INSERT:  cmd_ok = (count < DEPTH_C);
            OP_UPDATE:  cmd_ok = ({1'b0, index} < count);
            default:    cmd_ok = 1'b0;
         endcase
      end
      load_ok = data_valid && !busy && !cmd_ok && (count < DEPTH_C);
   end

   // Heap write ports: one write for loads and command setup, two for a swap.
   always_comb begin
      wa_en  = 1'b0;
      wa_idx = '0;
      wa_dat = '0;
      wb_en  = 1'b0;
      wb_idx = '0;
      wb_dat = '0;
      case (state)
         S_IDLE: begin
            if (cmd_ok) begin
               case (cmd)
                  OP_EXTRACT: begin
                     wa_en  = 1'b1;
                     wa_idx = '0;
                     wa_dat = last_d;
                  end
                  OP_INSERT: begin
                     wa_en  = 1'b1;
                     wa_idx = count[IW-1:0];
                     wa_dat = value;
                  end
                  OP_UPDATE: begin
                     wa_en  = upd_better;
                     wa_idx = index[IW-1:0];
                     wa_dat = value;
                  end
                  default: ;
               endcase
            end else if (load_ok) begin
               wa_en  = 1'b1;
               wa_idx = count[IW-1:0];
               wa_dat = data;
            end
         end
         S_SIFT_DN: begin
            if (swap_dn) begin
               wa_en  = 1'b1;
               wa_idx = cur[IW-1:0];
               wa_dat = best_d;
               wb_en  = 1'b1;
               wb_idx = pick_right ? rc[IW-1:0] : lc[IW-1:0];
               wb_dat = node_d;
            end
         end
         S_SIFT_UP: begin
            if (swap_up) begin
               wa_en  = 1'b1;
               wa_idx = cur[IW-1:0];
               wa_dat = par_d;
               wb_en  = 1'b1;
               wb_idx = par[IW-1:0];
               wb_dat = node_d;
            end
         end
         default: ;
      endcase
   end

   // Heap storage; contents are don't-care after reset, count defines validity.
   always_ff @(posedge clk) begin
      if (wa_en) heap[wa_idx] <= wa_dat;
      if (wb_en) heap[wb_idx] <= wb_dat;
   end

   // Control FSM: one compare-and-swap per cycle while sifting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         count     <= '0;
         cur       <= '0;
         bnode     <= '0;
         bld       <= 1'b0;
         ptr       <= '0;
         RAM_valid <= 1'b0;
         RAM_A     <= '0;
         RAM_D     <= '0;
         done      <= 1'b0;
      end else begin
         RAM_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_ok) begin
                  busy <= 1'b1;
                  case (cmd)
                     OP_BUILD: begin
                        bnode <= count[ADDR_W:1];
                        bld   <= 1'b1;
                        state <= S_BUILD;
                     end
                     OP_EXTRACT: begin
                        count <= count - 1;
                        cur   <= '0;
                        bld   <= 1'b0;
                        state <= S_SIFT_DN;
                     end
                     OP_UPDATE: begin
                        // A non-improving key changes nothing; start at the root
                        // so the ascent ends immediately.
                        cur   <= upd_better ? index : '0;
                        state <= S_SIFT_UP;
                     end
                     OP_INSERT: begin
                        cur   <= count[ADDR_W-1:0];
                        count <= count + 1;
                        state <= S_SIFT_UP;
                     end
                     OP_WRITE: begin
                        ptr   <= '0;
                        state <= S_WRITE;
                     end
                     default: busy <= 1'b0;
                  endcase
               end else if (load_ok) begin
                  count <= count + 1;
               end
            end
            S_BUILD: begin
               if (bnode == '0) begin
                  bld   <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cur   <= bnode - 1;
                  bnode <= bnode - 1;
                  state <= S_SIFT_DN;
               end
            end
            S_SIFT_DN: begin
               if (swap_dn) begin
                  cur <= pick_right ? rc[ADDR_W-1:0] : lc[ADDR_W-1:0];
               end else if (bld) begin
                  state <= S_BUILD;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_SIFT_UP: begin
               if (swap_up) begin
                  cur <= par;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_WRITE: begin
               if (ptr < count) begin
                  RAM_valid <= 1'b1;
                  RAM_A     <= ptr[ADDR_W-1:0];
                  RAM_D     <= heap[ptr[IW-1:0]];
                  ptr       <= ptr + 1;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MPQ_HEAP_ERR_EN
   // Flag a command strobe seen while idle that could not be executed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err <= 1'b0;
      else      err <= cmd_valid && !busy && !cmd_ok;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mpq_heap.sv
// tb_mpq_heap: drives a max-heap and a min-heap instance with identical
// stimulus and compares both against array-based reference heaps.
module tb_mpq_heap;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 8;
`ifdef MPQ_HEAP_ERR_EN
   localparam int ERR_EXP = 1;
`else
   localparam int ERR_EXP = 0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              data_valid;
   logic [DATA_W-1:0] data;
   logic              cmd_valid;
   logic [2:0]        cmd;
   logic [ADDR_W-1:0] index;
   logic [DATA_W-1:0] value;

   logic [1:0]        busy, ram_valid, done, err;
   logic [ADDR_W-1:0] ram_a [2];
   logic [DATA_W-1:0] ram_d [2];
   logic [ADDR_W:0]   cnt   [2];

   always #5 clk = ~clk;

   mpq_heap #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MIN_MODE(0)) u_max (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
      .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value),
      .busy(busy[0]), .RAM_valid(ram_valid[0]), .RAM_A(ram_a[0]), .RAM_D(ram_d[0]),
      .done(done[0]), .count(cnt[0]), .err(err[0]));

   mpq_heap #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MIN_MODE(1)) u_min (
      .clk(clk), .rst(rst), .data_valid(data_valid), .data(data),
      .cmd_valid(cmd_valid), .cmd(cmd), .index(index), .value(value),
      .busy(busy[1]), .RAM_valid(ram_valid[1]), .RAM_A(ram_a[1]), .RAM_D(ram_d[1]),
      .done(done[1]), .count(cnt[1]), .err(err[1]));

   // Output capture on the falling edge.
   int cap_a [2][$];
   int cap_d [2][$];
   int done_n [2];
   int err_n  [2];

   initial begin
      done_n = '{0, 0};
      err_n  = '{0, 0};
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (ram_valid[k] === 1'b1) begin
            cap_a[k].push_back(int'(ram_a[k]));
            cap_d[k].push_back(int'(ram_d[k]));
         end
         if (done[k] === 1'b1) done_n[k]++;
         if (err[k] === 1'b1)  err_n[k]++;
      end
   end

   // Reference heaps: index 0 = max-heap, 1 = min-heap; both share one size.
   int mh [2][DEPTH];
   int mcnt = 0;
   int last_w [2][DEPTH];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   function automatic bit mbetter(int k, int a, int b);
      return (k == 1) ? (a < b) : (a > b);
   endfunction

   task automatic m_down(int k, int start);
      int i, l, r, c, t;
      i = start;
      while (1) begin
         l = 2 * i + 1;
         r = l + 1;
         if (l >= mcnt) break;
         c = l;
         if (r < mcnt && mbetter(k, mh[k][r], mh[k][l])) c = r;
         if (!mbetter(k, mh[k][c], mh[k][i])) break;
         t = mh[k][c]; mh[k][c] = mh[k][i]; mh[k][i] = t;
         i = c;
      end
   endtask

   task automatic m_up(int k, int start);
      int i, p, t;
      i = start;
      while (i > 0) begin
         p = (i - 1) / 2;
         if (!mbetter(k, mh[k][i], mh[k][p])) break;
         t = mh[k][p]; mh[k][p] = mh[k][i]; mh[k][i] = t;
         i = p;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int v);
      data_valid = 1'b1;
      data       = v[DATA_W-1:0];
      step();
      data_valid = 1'b0;
      if (mcnt < DEPTH) begin
         mh[0][mcnt] = v;
         mh[1][mcnt] = v;
         mcnt++;
      end
   endtask

   task automatic send(input logic [2:0] c, input logic [ADDR_W-1:0] i, input logic [DATA_W-1:0] v);
      cmd       = c;
      index     = i;
      value     = v;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy != 2'b00 && n < 2000) begin
         step();
         n++;
      end
      data_valid = 1'b0;
      chk("idle_reached", busy, 0);
      step();
   endtask

   task automatic run(input logic [2:0] c, input int idx, input int val);
      bit rej;
      int e0 [2];
      case (c)
         3'd0, 3'd4: rej = 1'b0;
         3'd1:       rej = (mcnt == 0);
         3'd2:       rej = (idx >= mcnt);
         3'd3:       rej = (mcnt >= DEPTH);
         default:    rej = 1'b1;
      endcase
      e0 = err_n;
      send(c, idx[ADDR_W-1:0], val[DATA_W-1:0]);
      if (rej) chk("rejected_busy", busy, 0);
      wait_idle();
      if (!rej) begin
         case (c)
            3'd0: for (int k = 0; k < 2; k++)
                     for (int i = mcnt / 2 - 1; i >= 0; i--) m_down(k, i);
            3'd1: begin
               for (int k = 0; k < 2; k++) mh[k][0] = mh[k][mcnt-1];
               mcnt--;
               for (int k = 0; k < 2; k++) m_down(k, 0);
            end
            3'd2: for (int k = 0; k < 2; k++)
                     if (mbetter(k, val, mh[k][idx])) begin
                        mh[k][idx] = val;
                        m_up(k, idx);
                     end
            3'd3: begin
               for (int k = 0; k < 2; k++) mh[k][mcnt] = val;
               mcnt++;
               for (int k = 0; k < 2; k++) m_up(k, mcnt - 1);
            end
            default: ;
         endcase
      end
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("err_pulses_op%0d_d%0d", c, k), err_n[k] - e0[k], rej ? ERR_EXP : 0);
         chk($sformatf("count_op%0d_d%0d", c, k), cnt[k], mcnt);
      end
   endtask

   task automatic write_chk(input string tag, input bit inv);
      int b [2];
      int d0 [2];
      int n;
      bit bad;
      for (int k = 0; k < 2; k++) begin
         b[k]  = cap_a[k].size();
         d0[k] = done_n[k];
      end
      run(3'd4, 0, 0);
      for (int k = 0; k < 2; k++) begin
         n = cap_a[k].size() - b[k];
         chk($sformatf("%s_nwrites_d%0d", tag, k), n, mcnt);
         chk($sformatf("%s_done_d%0d", tag, k), done_n[k] - d0[k], 1);
         for (int i = 0; i < mcnt && i < n; i++) begin
            chk($sformatf("%s_addr_d%0d_%0d", tag, k, i), cap_a[k][b[k]+i], i);
            chk($sformatf("%s_data_d%0d_%0d", tag, k, i), cap_d[k][b[k]+i], mh[k][i]);
            last_w[k][i] = cap_d[k][b[k]+i];
         end
         if (inv) begin
            bad = 1'b0;
            for (int i = 1; i < mcnt && i < n; i++)
               if (mbetter(k, last_w[k][i], last_w[k][(i-1)/2])) bad = 1'b1;
            chk($sformatf("%s_order_d%0d", tag, k), bad, 0);
         end
      end
   endtask

   int e41 [8] = '{9, 6, 4, 1, 5, 3, 2, 1};
   int e42 [7] = '{6, 5, 4, 1, 1, 3, 2};
   int e43 [8] = '{7, 6, 4, 5, 1, 3, 2, 1};
   int d41 [8] = '{3, 1, 4, 1, 5, 9, 2, 6};

   initial begin
      int r, c0;
      rst        = 1'b0;
      data_valid = 1'b0;
      data       = '0;
      cmd_valid  = 1'b0;
      cmd        = '0;
      index      = '0;
      value      = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_busy", busy[k], 0);
         chk("reset_count", cnt[k], 0);
         chk("reset_ram_valid", ram_valid[k], 0);
         chk("reset_ram_a", ram_a[k], 0);
         chk("reset_ram_d", ram_d[k], 0);
         chk("reset_done", done[k], 0);
         chk("reset_err", err[k], 0);
      end
      @(negedge clk);
      rst = 1'b1;
      step();

      // Reference sequence: load, build, dump.
      for (int i = 0; i < 8; i++) load(d41[i]);
      chk("load8_count", cnt[0], 8);
      run(3'd0, 0, 0);
      write_chk("build", 1'b1);
      for (int i = 0; i < 8; i++) chk($sformatf("build_const_%0d", i), last_w[0][i], e41[i]);
      chk("min_root", last_w[1][0], 1);

      run(3'd1, 0, 0);
      write_chk("extract", 1'b1);
      chk("extract_count", cnt[0], 7);
      for (int i = 0; i < 7; i++) chk($sformatf("extract_const_%0d", i), last_w[0][i], e42[i]);

      run(3'd3, 0, 7);
      write_chk("insert", 1'b1);
      for (int i = 0; i < 8; i++) chk($sformatf("insert_const_%0d", i), last_w[0][i], e43[i]);

      run(3'd2, 6, 8);
      write_chk("update", 1'b1);
      chk("update_root", last_w[0][0], 8);

      // Not-better update leaves everything in place.
      run(3'd2, 0, 0);
      write_chk("update_nobetter", 1'b1);

      // Rejected commands: index out of range and undefined opcodes.
      run(3'd2, mcnt, 1);
      run(3'd5, 0, 0);
      run(3'd7, 0, 0);

      // Loads while busy are ignored.
      c0 = mcnt;
      send(3'd0, '0, '0);
      data_valid = 1'b1;
      data       = 8'hAA;
      wait_idle();
      for (int k = 0; k < 2; k++) for (int i = mcnt / 2 - 1; i >= 0; i--) m_down(k, i);
      chk("busy_load_ignored", cnt[0], c0);
      write_chk("busy_load", 1'b1);

      // Fill to capacity; extra load dropped, INSERT rejected.
      while (mcnt < DEPTH) load($urandom_range(0, 255));
      load(8'h33);
      chk("full_count", cnt[0], DEPTH);
      run(3'd3, 0, 8'h55);
      chk("full_insert_count", cnt[1], DEPTH);
      run(3'd0, 0, 0);
      write_chk("full", 1'b1);

      // Randomized mix of operations.
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1: repeat ($urandom_range(1, 3)) load($urandom_range(0, 255));
            2:    run(3'd0, 0, 0);
            3:    run(3'd1, 0, 0);
            4:    run(3'd3, 0, $urandom_range(0, 255));
            5:    run(3'd2, $urandom_range(0, mcnt), $urandom_range(0, 255));
            6:    run(3'($urandom_range(5, 7)), 0, 0);
            default: write_chk("rand", 1'b0);
         endcase
      end

      // Drain to empty, then reject EXTRACT and dump an empty heap.
      run(3'd0, 0, 0);
      while (mcnt > 0) run(3'd1, 0, 0);
      write_chk("empty", 1'b0);
      run(3'd1, 0, 0);
      write_chk("empty_again", 1'b0);

      // Reset asserted in the third busy cycle of a BUILD.
      for (int i = 0; i < 8; i++) load($urandom_range(0, 255));
      send(3'd0, '0, '0);
      step();
      step();
      chk("build_running", busy, 2'b11);
      rst = 1'b0;
      #1;
      mcnt = 0;
      for (int k = 0; k < 2; k++) begin
         chk("midrst_busy", busy[k], 0);
         chk("midrst_count", cnt[k], 0);
         chk("midrst_ram_valid", ram_valid[k], 0);
         chk("midrst_done", done[k], 0);
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      for (int i = 0; i < 10; i++) load($urandom_range(0, 255));
      run(3'd0, 0, 0);
      write_chk("post_reset", 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mpq_heap.md
MPQ_HEAP -- requirements
Module: mpq_heap

Interface
REQ-001 Parameter DATA_W, default 8, key width in bits.
REQ-002 Parameter DEPTH, default 16, maximum number of heap entries (2..256).
REQ-003 Parameter ADDR_W, default 8, width of the index and RAM address; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 Parameter MIN_MODE, default 0, selects a max-heap (0) or a min-heap (1).
REQ-005 clk  in  1  single clock; all state SHALL be updated on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-low.
REQ-007 data_valid  in  1  append `data` during the load phase.
REQ-008 data  in  DATA_W  load key.
REQ-009 cmd_valid  in  1  command strobe; accepted only while busy=0.
REQ-010 cmd  in  3  opcode: 000 BUILD, 001 EXTRACT, 010 UPDATE, 011 INSERT, 100 WRITE.
REQ-011 index  in  ADDR_W  0-based array slot for UPDATE.
REQ-012 value  in  DATA_W  key for UPDATE and INSERT.
REQ-013 busy  out  1  high while a command executes.
REQ-014 RAM_valid  out  1  RAM write strobe.
REQ-015 RAM_A  out  ADDR_W  RAM write address.
REQ-016 RAM_D  out  DATA_W  RAM write data.
REQ-017 done  out  1  one-cycle pulse after WRITE completes.
REQ-018 count  out  ADDR_W+1  current number of entries.
REQ-019 err  out  1  one-cycle pulse on a rejected command.

Function
REQ-020 "Better" SHALL mean strictly greater when MIN_MODE=0 and strictly less when MIN_MODE=1.
REQ-021 Load: each cycle with data_valid=1 SHALL store data at heap[count] and increment count; loads beyond DEPTH SHALL be dropped.
REQ-022 Command capture: a command SHALL be captured at the rising edge where cmd_valid=1 and busy=0, and busy SHALL be 1 from the next cycle until the command's last cycle.
REQ-023 FSM states SHALL be IDLE, BUILD, SIFT_DN, SIFT_UP and WRITE; IDLE is entered after every command.
REQ-024 Sift step: each cycle SHALL perform exactly one node compare-and-swap (one level of descent or ascent).
REQ-025 Sift-down SHALL swap the node with its better child only if that child is better than the node; on equal children the left child is chosen.
REQ-026 BUILD SHALL sift down nodes count/2-1 through 0 in order.
REQ-027 EXTRACT SHALL move heap[count-1] to the root, decrement count, then sift down from the root.
REQ-028 INSERT SHALL store value at heap[count], increment count, then sift up while the child is better than its parent.
REQ-029 UPDATE SHALL overwrite heap[index] and sift up only if value is better than the old key; a value not better than the old key SHALL leave the heap unchanged.
REQ-030 WRITE SHALL assert RAM_valid for count consecutive cycles with RAM_A = 0..count-1 and RAM_D = heap[RAM_A], then pulse done in the following cycle.
REQ-031 WRITE with count=0 SHALL perform no RAM writes and SHALL pulse done.
REQ-032 Rejected commands SHALL be ignored (busy stays 0): EXTRACT when empty, INSERT when full, UPDATE with index >= count, and undefined opcodes.
REQ-033 data_valid asserted while busy=1 SHALL be ignored.

Reset
REQ-034 While rst=0, count, busy, RAM_valid, RAM_A, RAM_D, done and err SHALL be 0 and the FSM SHALL be IDLE, including when reset is asserted mid-command.
REQ-035 Heap array contents SHALL NOT require reset.

Configuration
REQ-036 When MPQ_HEAP_ERR_EN is defined, each rejected command from REQ-032 SHALL pulse err for one cycle.
REQ-037 When MPQ_HEAP_ERR_EN is undefined, err SHALL be tied to 0, and rejected commands SHALL still be ignored.

Structure
REQ-038 A shared package mpq_pkg SHALL hold the opcode enum, the FSM state enum, and the better() compare function parameterised by MIN_MODE.
REQ-039 The design SHALL use one sub-module, mpq_cmp_swap: the combinational selection of the better of node, left child and right child.
REQ-040 The heap SHALL be a register array of DEPTH x DATA_W inside mpq_heap.

Verification (defaults unless stated)
REQ-041 Load 3,1,4,1,5,9,2,6; BUILD; WRITE -> RAM[0..7] = 9,6,4,1,5,3,2,1 and a single done pulse.
REQ-042 Continuing REQ-041, EXTRACT then WRITE -> count=7 and RAM[0..6] = 6,5,4,1,1,3,2.
REQ-043 Continuing REQ-042, INSERT 7 then WRITE -> RAM[0..7] = 7,6,4,5,1,3,2,1; then UPDATE index 6, value 8 -> root = 8.
REQ-044 With MIN_MODE=1, load the REQ-041 data, BUILD, WRITE -> RAM[0] = 1 and every parent <= its children.
REQ-045 With MPQ_HEAP_ERR_EN defined, load 16 entries, INSERT 0x55 -> err pulses once, count stays 16 and busy stays 0; EXTRACT on an empty heap -> err pulses once.
REQ-046 Assert rst=0 during the 3rd cycle of a BUILD -> busy=0 and count=0 immediately, and a subsequent load and BUILD completes normally.
